// File: rtl/unidade_busca_if.sv
// Instruction-memory fetch bus between the fetch unit and instruction memory.
//   imem_req  : fetch request (fetch unit -> memory)
//   imem_addr : byte address of the requested word (fetch unit -> memory)
//   imem_ack  : memory returns imem_data this cycle (memory -> fetch unit)
//   imem_data : instruction word, valid only with imem_ack (memory -> fetch unit)
interface unidade_busca_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/unidade_busca.sv
// Instruction fetch unit. Requests one word at a time from instruction memory,
// holds it for the downstream stages until released, then computes the next
// PC (sequential, taken branch or jump). A fetch that sees no acknowledge for
// TIMEOUT cycles parks the unit in a sticky error state until reset.
//   clock       : rising-edge clock for all state
//   reset       : synchronous active-high reset
//   imem        : fetch bus (master side)
//   stall       : downstream not ready; hold the current instruction
//   jump        : jump decoded for the held instruction
//   branch      : branch decoded for the held instruction
//   zero        : ALU zero flag for the held instruction
//   instr       : held instruction word
//   opCode      : instr[31:26], combinational
//   pc_out      : address the held instruction was fetched from
//   instr_valid : instr/opCode/pc_out valid
//   fetch_err   : sticky fetch-timeout flag
module unidade_busca #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    unidade_busca_if.master         imem,
    input  logic                    stall,
    input  logic                    jump,
    input  logic                    branch,
    input  logic                    zero,
    output logic [31:0]             instr,
    output logic [5:0]              opCode,
    output logic [31:0]             pc_out,
    output logic                    instr_valid,
    output logic                    fetch_err
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        ERR
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_out_q;
    logic [CW-1:0] wait_q;
    logic        imem_req_q;
    logic        instr_valid_q;
    logic        fetch_err_q;

    logic [31:0] pc_seq_d;
    logic [31:0] br_off_d;
    logic [31:0] pc_d;

    // Next PC is derived from the held instruction and its fetch address;
    // all additions wrap modulo 2^32. Jump wins over branch.
    always_comb begin
        pc_seq_d = pc_out_q + 32'd4;
        br_off_d = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        pc_d     = pc_seq_d;
        if (jump) begin
            pc_d = {pc_seq_d[31:28], instr_q[25:0], 2'b00};
        end else if (branch && zero) begin
            pc_d = pc_seq_d + br_off_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            pc_out_q      <= '0;
            wait_q        <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= REQ;
                    imem_req_q <= 1'b1;
                end
                REQ: begin
                    if (imem.imem_ack) begin
                        instr_q       <= imem.imem_data;
                        pc_out_q      <= pc_q;
                        wait_q        <= '0;
                        state_q       <= HOLD;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end else if (wait_q == CW'(TIMEOUT - 1)) begin
                        // This edge closes the TIMEOUT-th unacknowledged cycle.
                        state_q     <= ERR;
                        imem_req_q  <= 1'b0;
                        fetch_err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_q          <= pc_d;
                        state_q       <= REQ;
                        imem_req_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
                    end
                end
                ERR: begin
                    state_q       <= ERR;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                    fetch_err_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign opCode         = instr_q[31:26];
    assign pc_out         = pc_out_q;
    assign instr_valid    = instr_valid_q;
    assign fetch_err      = fetch_err_q;

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15, is the maximum number of REQ-state cycles without imem_ack before fault.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 imem_req  output  1  fetch request to instruction memory.
REQ-007 imem_addr  output  32  byte address of requested word; equals pc.
REQ-008 imem_ack  input  1  memory returns imem_data this cycle.
REQ-009 imem_data  input  32  instruction word, valid only when imem_ack=1.
REQ-010 stall  input  1  downstream not ready; hold current instruction.
REQ-011 jump  input  1  control-unit jump for the held instruction.
REQ-012 branch  input  1  control-unit branch for the held instruction.
REQ-013 zero  input  1  ALU zero flag for the held instruction.
REQ-014 instr  output  32  held instruction word.
REQ-015 opCode  output  6  instr[31:26], combinational from instr, feeds the control unit.
REQ-016 pc_out  output  32  address the held instruction was fetched from.
REQ-017 instr_valid  output  1  instr/opCode/pc_out valid.
REQ-018 fetch_err  output  1  sticky fetch-timeout flag.

Function
REQ-019 The block SHALL implement states IDLE, REQ, HOLD, ERR.
REQ-020 IDLE: all outputs inactive; SHALL move to REQ on the next clock unconditionally.
REQ-021 REQ: imem_req=1, imem_addr=pc; on imem_ack=1 SHALL capture imem_data into instr, pc into pc_out, clear the wait counter, go to HOLD.
REQ-022 REQ without imem_ack: the wait counter SHALL increment; when TIMEOUT cycles have elapsed without ack, the block SHALL go to ERR on that edge.
REQ-023 HOLD: instr_valid=1, imem_req=0; with stall=1 the block SHALL hold instr, pc_out, pc and state unchanged.
REQ-024 HOLD with stall=0: pc SHALL update on that edge and the state SHALL return to REQ; instr_valid deasserts the following cycle.
REQ-025 Next pc: jump=1 -> {pc_out[31:28]+carry-free pc_out+4 upper nibble, instr[25:0], 2'b00} (i.e. (pc_out+4)[31:28] concatenated); else branch=1 and zero=1 -> pc_out+4+(sign-extended instr[15:0] << 2); else pc_out+4.
REQ-026 jump SHALL take priority over branch when both are 1.
REQ-027 All PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-028 jump, branch, zero SHALL be sampled only in HOLD with stall=0; ignored in all other states.
REQ-029 imem_ack in IDLE, HOLD or ERR SHALL be ignored.
REQ-030 ERR: imem_req=0, instr_valid=0, fetch_err=1; state SHALL remain ERR until reset.
REQ-031 Instruction latency: instr_valid asserts exactly one cycle after the imem_ack cycle.

Reset
REQ-032 On reset=1 at a clock edge: state=IDLE, pc=RESET_PC, instr=0, pc_out=0, wait counter=0, imem_req=0, instr_valid=0, fetch_err=0.
REQ-033 Reset during REQ or HOLD SHALL abandon the outstanding fetch; the first request after reset SHALL use RESET_PC.
REQ-034 Reset SHALL be the only exit from ERR.

Verification
REQ-035 Reset, ack 2 cycles after each req with data 32'h0000_0000, stall=0 -> imem_addr sequence 0,4,8; opCode=0 in each HOLD.
REQ-036 Held instr 32'h0800_0010 at pc_out 0x0000_0040, jump=1 -> next imem_addr 0x0000_0040; jump=1 with branch=1,zero=1 -> still jump target.
REQ-037 Held instr 32'h1000_FFFF at pc_out 0x100, branch=1, zero=1 -> next imem_addr 0x100; zero=0 -> 0x104.
REQ-038 stall=1 for 5 cycles in HOLD -> instr, pc_out, instr_valid=1 stable, imem_req=0; release -> REQ next cycle.
REQ-039 No ack for 15 REQ cycles -> fetch_err=1, imem_req=0; later imem_ack ignored; reset -> fetch_err=0, imem_addr=RESET_PC.
REQ-040 Reset asserted in REQ with ack arriving same cycle -> data discarded, instr=0, next request at RESET_PC.
